// File: rtl/load_store_unit_if.sv
// Core request/response and DataMemory control bundle for the load/store unit.
// The slave modport is the LSU; master is the environment (core plus DataMemory).
interface load_store_unit_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 12
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [DEPTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;
    logic             MemWrite;
    logic             MemRead;
    logic             one_byte;
    logic             two_byte;
    logic             four_bytes;
    logic             unsigned_load;
    logic [DEPTH-1:0] Address;
    logic [WIDTH-1:0] WriteData;
    logic [WIDTH-1:0] ReadData;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ReadData,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output MemWrite, MemRead, one_byte, two_byte, four_bytes, unsigned_load, Address, WriteData
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ReadData,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  MemWrite, MemRead, one_byte, two_byte, four_bytes, unsigned_load, Address, WriteData
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time into DataMemory; misaligned halfwords and words
// are split into byte beats, reassembled little-endian and extended.
module load_store_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 12
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);

    localparam int AW = DEPTH + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    typedef struct packed {
        logic             write;
        logic [1:0]       size;
        logic             uns;
        logic [DEPTH-1:0] addr;
        logic [WIDTH-1:0] wdata;
        logic             split;
        logic [1:0]       last_beat;
        logic             err;
    } req_t;

    typedef struct packed {
        logic             write;
        logic             read;
        logic             one;
        logic             two;
        logic             four;
        logic             uns;
        logic [DEPTH-1:0] addr;
        logic [WIDTH-1:0] wdata;
    } mem_t;

    state_e           state_q, state_d;
    req_t             req_q, req_d, req_in;
    mem_t             mem_q, mem_d;
    logic [1:0]       beat_q, beat_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [AW-1:0]    span, end_addr;
    logic             aligned;

    // Decode the incoming request; the end-address check carries one extra bit so it cannot wrap.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        span = '0;
        case (bus.req_size)
            2'd0:    span = '0;
            2'd1:    span = AW'(1);
            default: span = AW'(3);
        endcase
        end_addr = {1'b0, bus.req_addr} + span;
        aligned  = (bus.req_size == 2'd0)
                || (bus.req_size == 2'd1 && !bus.req_addr[0])
                || (bus.req_size[1] && bus.req_addr[1:0] == 2'b00);

        req_in           = '0;
        req_in.write     = bus.req_write;
        req_in.size      = bus.req_size;
        req_in.uns       = bus.req_unsigned;
        req_in.addr      = bus.req_addr;
        req_in.wdata     = bus.req_wdata;
        req_in.split     = !aligned;
        req_in.last_beat = aligned ? 2'd0 : ((bus.req_size == 2'd1) ? 2'd1 : 2'd3);
        req_in.err       = end_addr[DEPTH];
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        beat_d  = beat_q;
        acc_d   = acc_q;
        rdata_d = rdata_q;
        mem_d   = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_d  = req_in;
                    beat_d = '0;
                    acc_d  = '0;
                    if (req_in.err) begin
                        state_d = DONE;
                        rdata_d = '0;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!req_q.write) begin
                    state_d = WAIT;
                end else if (beat_q == req_q.last_beat) begin
                    state_d = DONE;
                    rdata_d = '0;
                end else begin
                    beat_d  = beat_q + 2'd1;
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                if (req_q.split) begin
                    acc_d[{beat_q, 3'b000} +: 8] = bus.ReadData[7:0];
                end else begin
                    acc_d = bus.ReadData;
                end
                if (beat_q == req_q.last_beat) begin
                    state_d = DONE;
                    // Split halfwords were fetched zero-extended per byte; extend here instead.
                    if (req_q.split && req_q.size == 2'd1) begin
                        rdata_d = {{(WIDTH-16){~req_q.uns & acc_d[15]}}, acc_d[15:0]};
                    end else begin
                        rdata_d = acc_d;
                    end
                end else begin
                    beat_d  = beat_q + 2'd1;
                    state_d = ISSUE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Memory controls are registered: load the beat that the next ISSUE cycle presents.
        if (state_d == ISSUE) begin
            mem_d.write = req_d.write;
            mem_d.read  = !req_d.write;
            if (req_d.split) begin
                mem_d.one   = 1'b1;
                mem_d.uns   = 1'b1;
                mem_d.addr  = req_d.addr + DEPTH'(beat_d);
                mem_d.wdata = {{(WIDTH-8){1'b0}}, req_d.wdata[{beat_d, 3'b000} +: 8]};
            end else begin
                mem_d.one   = (req_d.size == 2'd0);
                mem_d.two   = (req_d.size == 2'd1);
                mem_d.four  = req_d.size[1];
                mem_d.uns   = req_d.uns;
                mem_d.addr  = req_d.addr;
                mem_d.wdata = req_d.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            mem_q   <= '0;
            beat_q  <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            req_q   <= req_d;
            mem_q   <= mem_d;
            beat_q  <= beat_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.resp_valid    = (state_q == DONE);
    assign bus.resp_err      = (state_q == DONE) && req_q.err;
    assign bus.resp_rdata    = rdata_q;
    assign bus.MemWrite      = mem_q.write;
    assign bus.MemRead       = mem_q.read;
    assign bus.one_byte      = mem_q.one;
    assign bus.two_byte      = mem_q.two;
    assign bus.four_bytes    = mem_q.four;
    assign bus.unsigned_load = mem_q.uns;
    assign bus.Address       = mem_q.addr;
    assign bus.WriteData     = mem_q.wdata;

endmodule
